arc4_crack: RTL
===============

ARC4_CRACK -- requirements
Module: arc4_crack

Interface
REQ-001 SHALL have parameter KEY_START, default 24'h000000, the first key tried.
REQ-002 SHALL have parameter KEY_LAST, default 24'hFFFFFF, the last key tried (KEY_LAST >= KEY_START).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port en, input, 1, start request, sampled only while rdy=1.
REQ-006 SHALL have port rdy, output, 1, high when idle and able to accept en.
REQ-007 SHALL have port key, output, 24, the recovered key, meaningful when key_valid=1.
REQ-008 SHALL have port key_valid, output, 1, high when the last search found a key.
REQ-009 SHALL have port arc_rst_n, output, 1, active-low reset to the decryption unit.
REQ-010 SHALL have port arc_en, output, 1, start pulse to the decryption unit.
REQ-011 SHALL have port arc_rdy, input, 1, ready from the decryption unit.
REQ-012 SHALL have port arc_key, output, 24, the key currently under test.
REQ-013 SHALL have port pt_addr, output, 8, plaintext memory read address.
REQ-014 SHALL have port pt_rddata, input, 8, plaintext read data, valid one cycle after pt_addr.

Function
REQ-015 SHALL implement states IDLE, ARST, ARM, WLOW, WDONE, RDLEN, CHECK and NEXT.
REQ-016 IDLE: rdy=1; en=1 SHALL load cur_key<=KEY_START, clear key_valid and key, and go to ARST; en=0 SHALL stay in IDLE.
REQ-017 ARST: arc_rst_n=0 for exactly one cycle with arc_key=cur_key, then go to ARM.
REQ-018 ARM: when arc_rdy=1, arc_en=1 for exactly one cycle, then go to WLOW; otherwise wait in ARM.
REQ-019 WLOW: wait for arc_rdy=0, then go to WDONE.
REQ-020 WDONE: wait for arc_rdy=1, then drive pt_addr=0 and go to RDLEN.
REQ-021 RDLEN: latch len<=pt_rddata.
  - len=0: message trivially valid, treat as success.
  - Otherwise drive pt_addr=1, set idx=1, and go to CHECK.
REQ-022 CHECK SHALL be pipelined at one byte per cycle: each cycle, check pt_rddata (for address idx) and issue the next address idx+1 while idx<len.
REQ-023 Byte check: a byte is printable if 0x20 <= byte <= 0x7E inclusive. Any non-printable byte SHALL abort the check and go to NEXT.
REQ-024 Success (byte idx==len printable, or len=0):
  - key<=cur_key, key_valid<=1.
  - Go to IDLE; rdy=1 in the following cycle.
REQ-025 NEXT:
  - cur_key==KEY_LAST: key<=0, key_valid<=0, go to IDLE.
  - Otherwise cur_key<=cur_key+1 and go to ARST.
REQ-026 cur_key SHALL not wrap; the KEY_LAST comparison happens before the increment, so 24'hFFFFFF is tried and the search then terminates.
REQ-027 rdy SHALL be 0 in every state except IDLE; en asserted while busy SHALL be ignored.
REQ-028 arc_key SHALL equal cur_key at all times and stay stable from ARST until NEXT.
REQ-029 arc_rst_n=1 and arc_en=0 outside ARST and ARM respectively; pt_addr SHALL hold its last value when not reading.
REQ-030 key and key_valid SHALL hold their values in IDLE until the next en is accepted.

Reset
REQ-031 rst=1 SHALL force state IDLE, rdy=1, key_valid=0, key=0, cur_key=KEY_START, arc_en=0, arc_rst_n=0 and pt_addr=0, in any state including mid-search.
REQ-032 After rst deasserts, arc_rst_n SHALL be 1 in IDLE; no search resumes until a new en.

Verification
REQ-033 Valid key found:
  - Bench arc4 model: rdy drops 1 cycle after arc_en and returns 12 cycles later; pt = len 5 "Hello" only when arc_key=3, else byte1=0x07.
  - en pulse -> four ARST pulses (keys 0..3), then key=24'h000003, key_valid=1, rdy=1.
REQ-034 Exhaustion: KEY_LAST=24'h000007 and no key valid -> exactly 8 arc_en pulses, then key_valid=0, key=0, rdy=1.
REQ-035 Byte boundaries:
  - Bytes {0x20,0x7E} pass; {0x1F} fails; {0x7F} fails. Each case is tested at the first, middle and last position of a len=3 message.
  - len=0 -> success with key=KEY_START on the first attempt.
REQ-036 Reset mid-run: rst=1 for 1 cycle while in WDONE at key 2 -> next cycle rdy=1, arc_rst_n=0 during reset, key_valid=0; a later en restarts at KEY_START.
REQ-037 Busy and repeat handling:
  - en held high during the search has no effect.
  - A second en after success clears key_valid in the accept cycle and repeats the search with an identical result.
  - pt_addr sequence per attempt is 0,1,2,...,len on consecutive cycles.

Source files
------------

// File: rtl/arc4_crack_if.sv
// Signal bundle between the key search engine and its environment:
// host handshake, decryption-unit control and plaintext memory port.
interface arc4_crack_if;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic        key_valid;
  logic        arc_rst_n;
  logic        arc_en;
  logic        arc_rdy;
  logic [23:0] arc_key;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_rddata;

  modport master (
    input  en, arc_rdy, pt_rddata,
    output rdy, key, key_valid, arc_rst_n, arc_en, arc_key, pt_addr
  );

  modport slave (
    output en, arc_rdy, pt_rddata,
    input  rdy, key, key_valid, arc_rst_n, arc_en, arc_key, pt_addr
  );
endinterface

// File: rtl/arc4_crack.sv
// Brute-force ARC4 key search: walks KEY_START..KEY_LAST, decrypts each candidate
// and accepts the first key whose length-prefixed plaintext is all printable ASCII.
module arc4_crack #(
  parameter logic [23:0] KEY_START = 24'h000000,
  parameter logic [23:0] KEY_LAST  = 24'hFFFFFF
) (
  input  logic         clk,
  input  logic         rst,
  arc4_crack_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, ARST, ARM, WLOW, WDONE, RDLEN, CHECK, NEXT
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] cur_key_q, cur_key_d;
  logic [23:0] key_q, key_d;
  logic        key_valid_q, key_valid_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  pt_addr_q, pt_addr_d;
  logic        arc_en_c;
  logic        arc_rst_n_c;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  always_comb begin
    state_d     = state_q;
    cur_key_d   = cur_key_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    len_d       = len_q;
    idx_d       = idx_q;
    pt_addr_d   = pt_addr_q;
    arc_en_c    = 1'b0;
    arc_rst_n_c = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.en) begin
          cur_key_d   = KEY_START;
          key_d       = '0;
          key_valid_d = 1'b0;
          state_d     = ARST;
        end
      end
      ARST: begin
        arc_rst_n_c = 1'b0;
        state_d     = ARM;
      end
      ARM: begin
        if (bus.arc_rdy) begin
          arc_en_c = 1'b1;
          state_d  = WLOW;
        end
      end
      WLOW: begin
        if (!bus.arc_rdy) state_d = WDONE;
      end
      WDONE: begin
        // Address goes out combinationally so the length byte lands in RDLEN.
        if (bus.arc_rdy) begin
          pt_addr_d = 8'd0;
          state_d   = RDLEN;
        end
      end
      RDLEN: begin
        len_d = bus.pt_rddata;
        if (bus.pt_rddata == 8'd0) begin
          key_d       = cur_key_q;
          key_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          pt_addr_d = 8'd1;
          idx_d     = 8'd1;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        // pt_rddata holds byte idx_q while address idx_q+1 is already issued.
        if (!is_printable(bus.pt_rddata)) begin
          state_d = NEXT;
        end else if (idx_q >= len_q) begin
          key_d       = cur_key_q;
          key_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          pt_addr_d = idx_q + 8'd1;
          idx_d     = idx_q + 8'd1;
        end
      end
      NEXT: begin
        if (cur_key_q == KEY_LAST) begin
          key_d       = '0;
          key_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          cur_key_d = cur_key_q + 24'd1;
          state_d   = ARST;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset also holds the decryption unit in reset and parks the memory port.
    if (rst) begin
      arc_en_c    = 1'b0;
      arc_rst_n_c = 1'b0;
      pt_addr_d   = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_key_q   <= KEY_START;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      len_q       <= '0;
      idx_q       <= '0;
      pt_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_key_q   <= cur_key_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      pt_addr_q   <= pt_addr_d;
    end
  end

  assign bus.rdy       = (state_q == IDLE);
  assign bus.key       = key_q;
  assign bus.key_valid = key_valid_q;
  assign bus.arc_key   = cur_key_q;
  assign bus.arc_en    = arc_en_c;
  assign bus.arc_rst_n = arc_rst_n_c;
  assign bus.pt_addr   = pt_addr_d;

endmodule
